vram_fetch_arbiter: RTL and testbench



---
 rtl/vram_fetch_arbiter.sv | 154 +++++++++++++++
 tb/tb_vram_fetch_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_arbiter.sv
// vram_fetch_arbiter: shares one single-port VRAM between the
// scanline prefetcher and a CPU port, video first with a bounded CPU share.
module vram_fetch_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int LB_AW       = 6,
    parameter int FETCH_WORDS = 40,
    parameter int STRIDE      = 40,
    parameter int V_ACTIVE    = 480,
    parameter int CPU_EVERY   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              next_frame,
    input  logic              next_line,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int SW = $clog2(CPU_EVERY + 1);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t            r_state;
    logic [LW-1:0]     r_line_idx;
    logic [ADDR_W-1:0] r_line_addr;
    logic [ADDR_W-1:0] r_base;
    logic [LB_AW-1:0]  r_word_cnt;
    logic [SW-1:0]     r_slot_cnt;
    logic              r_bank;
    logic              r_lb_we;
    logic [LB_AW-1:0]  r_lb_addr;
    logic              r_cpu_ack;
    logic              r_underrun;

    logic              w_fetch;
    logic              w_cpu_elig;
    logic              w_cpu_gnt;
    logic              w_vid_gnt;
    logic              w_abort;
    logic              w_start;
    logic [LW-1:0]     w_idx;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_vid_addr;

    // A same-cycle next_frame is visible to the next_line it accompanies.
    assign w_idx   = next_frame ? '0 : r_line_idx;
    assign w_addr  = next_frame ? frame_base : r_line_addr;
    assign w_start = next_line && (w_idx < LW'(V_ACTIVE));

    assign w_fetch    = (r_state == S_FETCH);
    assign w_abort    = next_line && w_fetch;
    assign w_cpu_elig = rst_n && cpu_req && !r_cpu_ack;
    assign w_cpu_gnt  = w_cpu_elig &&
                        (!w_fetch || (r_slot_cnt == SW'(CPU_EVERY)));
    assign w_vid_gnt  = rst_n && w_fetch && !w_cpu_gnt && !w_abort;
    assign w_vid_addr = r_base + ADDR_W'(r_word_cnt);

    assign mem_en    = w_cpu_gnt || w_vid_gnt;
    assign mem_we    = w_cpu_gnt && cpu_we;
    assign mem_addr  = w_cpu_gnt ? cpu_addr :
                       (w_vid_gnt ? w_vid_addr : '0);
    assign mem_wdata = (w_cpu_gnt && cpu_we) ? cpu_wdata : '0;

    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_ack ? mem_rdata : '0;
    assign lb_we     = r_lb_we;
    assign lb_bank   = r_bank;
    assign lb_addr   = r_lb_addr;
    assign lb_wdata  = r_lb_we ? mem_rdata : '0;
    assign underrun  = r_underrun;

    // Line sequencing FSM: trigger, word issue, abort and bank flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_line_idx  <= LW'(V_ACTIVE);
            r_line_addr <= '0;
            r_base      <= '0;
            r_word_cnt  <= '0;
            r_bank      <= 1'b0;
            r_lb_we     <= 1'b0;
            r_lb_addr   <= '0;
        end else begin
            r_lb_we <= w_vid_gnt;
            if (w_vid_gnt) begin
                r_lb_addr  <= r_word_cnt;
                r_word_cnt <= r_word_cnt + 1'b1;
                if (r_word_cnt == LB_AW'(FETCH_WORDS - 1)) begin
                    r_state <= S_IDLE;
                end
            end
            if (next_frame) begin
                r_line_idx  <= '0;
                r_line_addr <= frame_base;
            end
            if (w_abort) begin
                r_state <= S_IDLE;
            end
            if (w_start) begin
                r_state     <= S_FETCH;
                r_word_cnt  <= '0;
                r_base      <= w_addr;
                r_line_addr <= w_addr + ADDR_W'(STRIDE);
                r_line_idx  <= w_idx + 1'b1;
                r_bank      <= (w_idx == '0) ? 1'b0 : !r_bank;
            end
        end
    end

    // CPU completion pulse and the count of video wins it has waited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_ack  <= 1'b0;
            r_slot_cnt <= '0;
        end else begin
            r_cpu_ack <= w_cpu_gnt;
            if (!cpu_req || w_cpu_gnt) begin
                r_slot_cnt <= '0;
            end else if (w_vid_gnt && w_cpu_elig) begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    // Sticky late-fetch flag; a new underrun beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_abort) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// tb_vram_fetch_arbiter: random line/CPU traffic against a
// behavioural model of the fetch schedule and a shadow VRAM.
module tb_vram_fetch_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAW = 6;
    localparam int FW  = 40;
    localparam int STR = 40;
    localparam int VA  = 480;
    localparam int CE  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           next_frame = 1'b0;
    logic           next_line = 1'b0;
    logic [AW-1:0]  frame_base = '0;
    logic           cpu_req = 1'b0;
    logic           cpu_we = 1'b0;
    logic [AW-1:0]  cpu_addr = '0;
    logic [DW-1:0]  cpu_wdata = '0;
    logic           cpu_ack;
    logic [DW-1:0]  cpu_rdata;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata = '0;
    logic           lb_we;
    logic           lb_bank;
    logic [LAW-1:0] lb_addr;
    logic [DW-1:0]  lb_wdata;
    logic           underrun;
    logic           underrun_clr = 1'b0;

    vram_fetch_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LB_AW(LAW),
        .FETCH_WORDS(FW), .STRIDE(STR),
        .V_ACTIVE(VA), .CPU_EVERY(CE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .next_frame(next_frame), .next_line(next_line),
        .frame_base(frame_base),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_bank(lb_bank),
        .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // VRAM seen by the DUT, and the bench's own copy of what it should hold
    logic [DW-1:0] vram   [0:65535];
    logic [DW-1:0] shadow [0:65535];
    logic          q_en, q_we;
    logic [AW-1:0] q_addr;
    logic [DW-1:0] q_wdata;

    always @(negedge clk) begin
        q_en = mem_en; q_we = mem_we;
        q_addr = mem_addr; q_wdata = mem_wdata;
    end

    always @(posedge clk) begin
        if (q_en) begin
            if (q_we) vram[q_addr] <= q_wdata;
            else mem_rdata <= vram[q_addr];
        end
    end

    // Reference model state
    logic           m_fetch, m_bank, m_unr;
    logic           m_lb_due, m_lb_bank, m_ack_due, m_ack_rd;
    int             m_word, m_line, m_slot;
    logic [AW-1:0]  m_base, m_fbase;
    logic [DW-1:0]  m_lb_data, m_ack_data;
    logic [LAW-1:0] m_lb_k;
    int             mem_cnt = 0;
    int             lbw_cnt = 0;

    always @(negedge clk) begin
        logic          elig, cg, vg, nlf;
        logic [AW-1:0] va;
        if (!rst_n) begin
            m_fetch = 0; m_bank = 0; m_unr = 0;
            m_lb_due = 0; m_ack_due = 0; m_ack_rd = 0;
            m_word = 0; m_line = VA; m_slot = 0;
            m_base = '0; m_fbase = '0;
        end else begin
            if (mem_en) mem_cnt++;
            if (lb_we) lbw_cnt++;
            chk("lb_we", lb_we, m_lb_due);
            if (m_lb_due)
                chk("lb_bank_addr_data",
                    {lb_bank, lb_addr, lb_wdata},
                    {m_lb_bank, m_lb_k, m_lb_data});
            chk("cpu_ack", cpu_ack, m_ack_due);
            if (m_ack_due && m_ack_rd)
                chk("cpu_rdata", cpu_rdata, m_ack_data);
            chk("underrun", underrun, m_unr);

            elig = cpu_req && !m_ack_due;
            nlf  = next_line && m_fetch;
            cg   = elig && (!m_fetch || m_slot == CE);
            vg   = m_fetch && !cg && !nlf;
            va   = AW'(m_base + AW'(m_word));
            chk("mem_en_we", {mem_en, mem_we},
                {cg || vg, cg && cpu_we});
            if (cg)
                chk("mem_addr_cpu", mem_addr, cpu_addr);
            if (cg && cpu_we)
                chk("mem_wdata", mem_wdata, cpu_wdata);
            if (vg)
                chk("mem_addr_vid", mem_addr, va);

            m_ack_due = cg;
            m_ack_rd  = !cpu_we;
            m_ack_data = shadow[cpu_addr];
            if (cg && cpu_we) shadow[cpu_addr] = cpu_wdata;
            m_lb_due  = vg;
            m_lb_k    = LAW'(m_word);
            m_lb_bank = m_bank;
            m_lb_data = shadow[va];

            if (!cpu_req || cg) m_slot = 0;
            else if (vg && elig) m_slot++;

            if (vg) begin
                m_word++;
                if (m_word == FW) m_fetch = 0;
            end
            if (nlf) begin
                m_unr = 1;
                m_fetch = 0;
            end else if (underrun_clr) begin
                m_unr = 0;
            end
            if (next_frame) begin
                m_fbase = frame_base;
                m_line = 0;
            end
            if (next_line && m_line < VA) begin
                m_fetch = 1;
                m_word = 0;
                m_base = AW'(m_fbase + m_line * STR);
                m_bank = (m_line == 0) ? 1'b0 : !m_bank;
                m_line++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_line(input logic nf, input logic [AW-1:0] fb);
        next_frame = nf;
        frame_base = fb;
        next_line  = 1'b1;
        tick(1);
        next_line  = 1'b0;
        next_frame = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        bit got = 0;
        cpu_we = we; cpu_addr = a; cpu_wdata = d;
        cpu_req = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) got = 1;
        end
        chk("cpu_ack_wait", got, 1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_a"},
            {cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr}, 0);
        chk({tag, "_b"},
            {mem_wdata, lb_we, lb_bank, lb_addr, lb_wdata, underrun}, 0);
    endtask

    bit cpu_run  = 0;
    bit cpu_busy = 0;

    task automatic cpu_traffic();
        cpu_busy = 1;
        while (cpu_run) begin
            tick($urandom_range(1, 7));
            if (cpu_run)
                cpu_access(1'($urandom_range(0, 1)),
                           AW'(16'h1000 + $urandom_range(0, 255)),
                           DW'($urandom));
        end
        cpu_busy = 0;
    endtask

    initial begin
        int gap;
        for (int i = 0; i < 65536; i++) begin
            vram[i]   = DW'((i * 40503) ^ 23130);
            shadow[i] = vram[i];
        end

        tick(3);
        rst_chk("reset_state");
        rst_n = 1'b1;
        tick(2);

        mem_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            pulse_line(1'b0, 16'h0);
            tick(10);
        end
        chk("no_frame_no_access", mem_cnt, 0);

        mem_cnt = 0; lbw_cnt = 0;
        pulse_line(1'b1, 16'h1000);
        tick(45);
        chk("line0_reads", mem_cnt, FW);
        chk("line0_lbw", lbw_cnt, FW);

        mem_cnt = 0;
        pulse_line(1'b0, 16'h0);
        tick(45);
        chk("line1_reads", mem_cnt, FW);

        mem_cnt = 0; lbw_cnt = 0;
        pulse_line(1'b0, 16'h0);
        cpu_access(1'b0, 16'h0005, 16'h0);
        tick(50);
        chk("contend_mem", mem_cnt, FW + 1);
        chk("contend_lbw", lbw_cnt, FW);

        cpu_access(1'b1, 16'h2000, 16'hBEEF);
        cpu_access(1'b0, 16'h2000, 16'h0);
        chk("idle_rd_back", cpu_rdata, 16'h0);
        tick(3);

        pulse_line(1'b0, 16'h0);
        tick(9);
        pulse_line(1'b0, 16'h0);
        chk("unr_set", underrun, 1);
        tick(5);
        underrun_clr = 1'b1;
        pulse_line(1'b0, 16'h0);
        underrun_clr = 1'b0;
        chk("unr_set_beats_clr", underrun, 1);
        tick(50);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        chk("unr_clr", underrun, 0);

        pulse_line(1'b0, 16'h0);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        rst_chk("reset_midfetch");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        mem_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            pulse_line(1'b0, 16'h0);
            tick(8);
        end
        chk("post_reset_no_access", mem_cnt, 0);

        cpu_run = 1;
        fork
            cpu_traffic();
        join_none
        pulse_line(1'b1, AW'($urandom));
        for (int l = 0; l < 250; l++) begin
            gap = ($urandom_range(0, 7) == 0) ?
                  $urandom_range(6, 39) : $urandom_range(41, 60);
            underrun_clr = ($urandom_range(0, 3) == 0);
            tick(1);
            underrun_clr = 1'b0;
            tick(gap - 1);
            pulse_line($urandom_range(0, 40) == 0, AW'($urandom));
        end
        cpu_run = 0;
        for (int i = 0; i < 100 && cpu_busy; i++) tick(1);
        chk("cpu_drain", cpu_busy, 0);
        tick(60);

        pulse_line(1'b1, 16'h0100);
        for (int l = 1; l < VA; l++) begin
            tick(FW);
            pulse_line(1'b0, 16'h0);
        end
        tick(45);
        mem_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            pulse_line(1'b0, 16'h0);
            tick(10);
        end
        chk("past_vactive_no_access", mem_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
